// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Bundles the operation handshake, operand/result bus and branch-decision
// signals of alu_seq.
//   master : requester side (register-file read / decode stage)
//   slave  : alu_seq itself
// Signals:
//   In_valid/In_ready   operation handshake (accept = In_valid & In_ready)
//   Alu_op, Signed_cmp  operation select and compare signedness
//   DatA, DatB          operands
//   Out_valid           one-cycle result strobe
//   Rslt, Rslt_hi       result (MUL low half) and MUL high half
//   Br_en, Br_cond      branch request and condition select
//   Branch              branch taken
//   Flags               {carry, overflow, gt, eq, lt}
// -----------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             In_valid;
   logic             In_ready;
   logic [3:0]       Alu_op;
   logic             Signed_cmp;
   logic [WIDTH-1:0] DatA;
   logic [WIDTH-1:0] DatB;
   logic             Out_valid;
   logic [WIDTH-1:0] Rslt;
   logic [WIDTH-1:0] Rslt_hi;
   logic             Br_en;
   logic [2:0]       Br_cond;
   logic             Branch;
   logic [4:0]       Flags;

   modport master (
      output In_valid, Alu_op, Signed_cmp, DatA, DatB, Br_en, Br_cond,
      input  In_ready, Out_valid, Rslt, Rslt_hi, Branch, Flags
   );

   modport slave (
      input  In_valid, Alu_op, Signed_cmp, DatA, DatB, Br_en, Br_cond,
      output In_ready, Out_valid, Rslt, Rslt_hi, Branch, Flags
   );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked WIDTH-bit ALU sitting between register-file read and
// writeback/PC logic. Single-cycle ops (ADD, SUB, AND, XOR, SHL, SHR, CMP,
// ABS, MOV) produce a registered result one edge after acceptance. MUL is an
// unsigned iterative shift-add multiplier: the accepting edge performs the
// first add-shift step and WIDTH-1 further steps follow, so the full
// 2*WIDTH-bit product appears WIDTH edges after the accepting cycle.
// Condition flags are registered; Branch is combinational from them.
// Ports:
//   Clk      clock, all state on the rising edge
//   Reset_n  synchronous active-low reset
//   bus      alu_seq_if slave modport (handshake, operands, results, branch)
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input logic      Clk,
   input logic      Reset_n,
   alu_seq_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_SHL = 4'd4;
   localparam logic [3:0] OP_SHR = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [3:0] OP_ABS = 4'd8;
   localparam logic [3:0] OP_MOV = 4'd9;

   // Flag bit positions within Flags = {carry, overflow, gt, eq, lt}
   localparam int FL_LT = 0;
   localparam int FL_EQ = 1;
   localparam int FL_GT = 2;
   localparam int FL_OV = 3;
   localparam int FL_CY = 4;

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [SHW-1:0]   SH_LIMIT = SHW'(WIDTH);
   localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_e;

   // ---------------------------------------------------------------------------
   // Control and result registers
   // ---------------------------------------------------------------------------
   state_e           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_rslt;
   logic [WIDTH-1:0] r_rslt_hi;
   logic [4:0]       r_flags;

   // Multiplier working registers (pure datapath, no reset needed)
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   logic                    w_accept;
   logic                    w_is_mul;
   logic [WIDTH:0]          w_sum;
   logic [WIDTH:0]          w_diff;
   logic [WIDTH-1:0]        w_neg_a;
   logic signed [WIDTH-1:0] w_sa;
   logic signed [WIDTH-1:0] w_sb;
   logic [SHW-1:0]          w_shamt;
   logic [WIDTH-1:0]        w_rslt;
   logic [4:0]              w_flags;
   logic [2*WIDTH-1:0]      w_step_first;
   logic [2*WIDTH-1:0]      w_step;
   logic                    w_cond;

   // Logical shifts; an amount of WIDTH or more clears the result.
   function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] a,
                                                   input logic [SHW-1:0]   amt);
      if (amt >= SH_LIMIT) begin
         return '0;
      end
      return a << amt;
   endfunction

   function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] a,
                                                    input logic [SHW-1:0]   amt);
      if (amt >= SH_LIMIT) begin
         return '0;
      end
      return a >> amt;
   endfunction

   // One add-shift step of the unsigned multiplier. {hi, lo} holds the partial
   // product in hi and the not-yet-consumed multiplier bits in lo; the carry
   // out of the add becomes the new MSB as everything shifts right by one.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo,
                                                   input logic [WIDTH-1:0] mcand);
      logic [WIDTH:0] sum;
      sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      return {sum, lo[WIDTH-1:1]};
   endfunction

   assign bus.In_ready = (r_state == ST_IDLE);
   assign w_accept     = Reset_n && bus.In_valid && (r_state == ST_IDLE);
   assign w_is_mul     = (bus.Alu_op == OP_MUL);

   assign w_sum   = {1'b0, bus.DatA} + {1'b0, bus.DatB};
   assign w_diff  = {1'b0, bus.DatA} - {1'b0, bus.DatB};
   assign w_neg_a = -bus.DatA;
   assign w_sa    = bus.DatA;
   assign w_sb    = bus.DatB;
   assign w_shamt = bus.DatB[SHW-1:0];

   // The accepting edge consumes multiplier bit 0 straight from the operands,
   // so only WIDTH-1 busy cycles follow.
   assign w_step_first = mul_step('0, bus.DatB, bus.DatA);
   assign w_step       = mul_step(r_acc_hi, r_acc_lo, r_mcand);

   // ---------------------------------------------------------------------------
   // Single-cycle result and flag computation
   // ---------------------------------------------------------------------------
   always_comb begin
      w_rslt  = '0;
      w_flags = r_flags;
      case (bus.Alu_op)
         OP_ADD: begin
            w_rslt         = w_sum[WIDTH-1:0];
            w_flags[FL_CY] = w_sum[WIDTH];
            w_flags[FL_OV] = (bus.DatA[WIDTH-1] == bus.DatB[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != bus.DatA[WIDTH-1]);
         end
         OP_SUB: begin
            w_rslt         = w_diff[WIDTH-1:0];
            // The extra MSB of the widened difference is the borrow.
            w_flags[FL_CY] = w_diff[WIDTH];
            w_flags[FL_OV] = (bus.DatA[WIDTH-1] != bus.DatB[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != bus.DatA[WIDTH-1]);
         end
         OP_AND: w_rslt = bus.DatA & bus.DatB;
         OP_XOR: w_rslt = bus.DatA ^ bus.DatB;
         OP_SHL: w_rslt = shift_left(bus.DatA, w_shamt);
         OP_SHR: w_rslt = shift_right(bus.DatA, w_shamt);
         OP_CMP: begin
            if (bus.Signed_cmp) begin
               w_flags[FL_LT] = (w_sa < w_sb);
               w_flags[FL_EQ] = (w_sa == w_sb);
               w_flags[FL_GT] = (w_sa > w_sb);
            end else begin
               w_flags[FL_LT] = (bus.DatA < bus.DatB);
               w_flags[FL_EQ] = (bus.DatA == bus.DatB);
               w_flags[FL_GT] = (bus.DatA > bus.DatB);
            end
         end
         OP_ABS: begin
            // The most negative value has no positive counterpart; it passes
            // through unchanged and is reported as overflow.
            w_rslt         = bus.DatA[WIDTH-1] ? w_neg_a : bus.DatA;
            w_flags[FL_OV] = (bus.DatA == MIN_NEG);
         end
         OP_MOV: w_rslt = bus.DatB;
         default: w_rslt = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control FSM, result and flag registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_rslt      <= '0;
         r_rslt_hi   <= '0;
         r_flags     <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_state <= ST_MUL;
                     r_cnt   <= CW'(1);
                  end else begin
                     r_out_valid <= 1'b1;
                     r_rslt      <= w_rslt;
                     r_rslt_hi   <= '0;
                     r_flags     <= w_flags;
                  end
               end
            end
            ST_MUL: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == MUL_LAST) begin
                  r_state        <= ST_IDLE;
                  r_cnt          <= '0;
                  r_out_valid    <= 1'b1;
                  r_rslt         <= w_step[WIDTH-1:0];
                  r_rslt_hi      <= w_step[2*WIDTH-1:WIDTH];
                  r_flags[FL_OV] <= |w_step[2*WIDTH-1:WIDTH];
                  r_flags[FL_CY] <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Multiplier datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (w_accept && w_is_mul) begin
         r_mcand  <= bus.DatA;
         r_acc_hi <= w_step_first[2*WIDTH-1:WIDTH];
         r_acc_lo <= w_step_first[WIDTH-1:0];
      end else if (r_state == ST_MUL) begin
         r_acc_hi <= w_step[2*WIDTH-1:WIDTH];
         r_acc_lo <= w_step[WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Branch decision from registered flags (no forwarding)
   // ---------------------------------------------------------------------------
   always_comb begin
      w_cond = 1'b0;
      case (bus.Br_cond)
         3'd0: w_cond = 1'b1;
         3'd1: w_cond = r_flags[FL_LT] | r_flags[FL_EQ];
         3'd2: w_cond = r_flags[FL_LT];
         3'd3: w_cond = r_flags[FL_EQ];
         3'd4: w_cond = ~r_flags[FL_EQ];
         3'd5: w_cond = r_flags[FL_GT] | r_flags[FL_EQ];
         3'd6: w_cond = r_flags[FL_GT];
         3'd7: w_cond = r_flags[FL_OV];
         default: w_cond = 1'b0;
      endcase
   end

   assign bus.Branch    = bus.Br_en & w_cond;
   assign bus.Out_valid = r_out_valid;
   assign bus.Rslt      = r_rslt;
   assign bus.Rslt_hi   = r_rslt_hi;
   assign bus.Flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at WIDTH=8: directed scenarios from the
// operation rules plus randomized operations compared against an arithmetic
// reference model of results, flags and branch decisions.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W   = 8;
   localparam int SHW = $clog2(W) + 1;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic [4:0] m_flags;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
      $fatal(1, "watchdog");
   end

   // Reference model: results and flags from plain integer arithmetic.
   // Flags layout {carry, overflow, gt, eq, lt}.
   function automatic void model(input int op, input longint a, input longint b,
                                 input bit sc, input logic [4:0] fin,
                                 output longint r, output longint hi,
                                 output logic [4:0] fo);
      longint full, half, sa, sb, s, amt, x, y, p;
      full = longint'(1) << W;
      half = full / 2;
      sa = (a >= half) ? a - full : a;
      sb = (b >= half) ? b - full : b;
      amt = b % (longint'(1) << SHW);
      fo = fin;
      r = 0;
      hi = 0;
      case (op)
         0: begin
            s = a + b; r = s % full; fo[4] = (s >= full);
            s = sa + sb; fo[3] = (s < -half) || (s >= half);
         end
         1: begin
            s = a - b; r = (s + full) % full; fo[4] = (a < b);
            s = sa - sb; fo[3] = (s < -half) || (s >= half);
         end
         2: r = a & b;
         3: r = a ^ b;
         4: r = (amt >= W) ? 0 : (a << amt) % full;
         5: r = (amt >= W) ? 0 : (a >> amt);
         6: begin
            x = sc ? sa : a;
            y = sc ? sb : b;
            fo[0] = (x < y); fo[1] = (x == y); fo[2] = (x > y);
         end
         7: begin
            p = a * b; r = p % full; hi = p / full;
            fo[3] = (hi != 0); fo[4] = 1'b0;
         end
         8: begin
            r = (sa < 0) ? (-sa) % full : a;
            fo[3] = (sa == -half);
         end
         9: r = b;
         default: r = 0;
      endcase
   endfunction

   function automatic bit br_model(input bit en, input int cond, input logic [4:0] f);
      bit c;
      case (cond)
         0: c = 1'b1;
         1: c = f[0] || f[1];
         2: c = f[0];
         3: c = f[1];
         4: c = !f[1];
         5: c = f[2] || f[1];
         6: c = f[2];
         default: c = f[3];
      endcase
      return en && c;
   endfunction

   // Drives one operation, waits (bounded) for acceptance and for Out_valid.
   // Entered and left 1 time unit after a rising edge; on return the result
   // cycle is current so outputs can be sampled directly.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit sc,
                         output bit got, output int lat);
      int waitc;
      bus.In_valid   = 1'b1;
      bus.Alu_op     = op;
      bus.DatA       = a;
      bus.DatB       = b;
      bus.Signed_cmp = sc;
      waitc = 0;
      while (!bus.In_ready && waitc < 40) begin
         @(posedge clk); #1;
         waitc++;
      end
      @(posedge clk); #1;
      bus.In_valid = 1'b0;
      lat = 1;
      while (!bus.Out_valid && lat < W + 4) begin
         @(posedge clk); #1;
         lat++;
      end
      got = bus.Out_valid;
   endtask

   task automatic test_reset;
      rst_n          = 1'b0;
      bus.In_valid   = 1'b1;
      bus.Alu_op     = 4'd0;
      bus.DatA       = 8'h11;
      bus.DatB       = 8'h22;
      bus.Signed_cmp = 1'b0;
      bus.Br_en      = 1'b1;
      bus.Br_cond    = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus.Out_valid, bus.Rslt, bus.Rslt_hi, bus.Flags, bus.In_ready} !== {1'b0, 8'h00, 8'h00, 5'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got ov=%b r=%h hi=%h f=%b rdy=%b, required 0 00 00 00000 1",
                  bus.Out_valid, bus.Rslt, bus.Rslt_hi, bus.Flags, bus.In_ready);
      end
      n_checks++;
      if (bus.Branch !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_br_always: got %b, required 1", bus.Branch);
      end
      bus.Br_cond = 3'd3; #1;
      n_checks++;
      if (bus.Branch !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_br_beq: got %b, required 0", bus.Branch);
      end
      bus.In_valid = 1'b0;
      bus.Br_en    = 1'b0;
      rst_n        = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.Out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ignored_input: got Out_valid=%b, required 0", bus.Out_valid);
      end
      m_flags = 5'b0;
   endtask

   task automatic test_add_sub;
      bit got; int lat; longint r, hi;
      run_op(4'd0, 8'h7F, 8'h01, 1'b0, got, lat);
      model(0, 8'h7F, 8'h01, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, lat, bus.Rslt, bus.Flags[4:3]} !== {1'b1, 32'd1, 8'h80, 2'b01}) begin
         n_fail++;
         $display("FAIL add_7f_01: got v=%b lat=%0d r=%h cy/ov=%b, required 1 1 80 01", got, lat, bus.Rslt, bus.Flags[4:3]);
      end
      // Idle cycle: strobe drops, result holds.
      @(posedge clk); #1;
      n_checks++;
      if ({bus.Out_valid, bus.Rslt} !== {1'b0, 8'h80}) begin
         n_fail++;
         $display("FAIL hold_after_add: got v=%b r=%h, required 0 80", bus.Out_valid, bus.Rslt);
      end
      run_op(4'd0, 8'hFF, 8'h01, 1'b0, got, lat);
      model(0, 8'hFF, 8'h01, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt, bus.Rslt_hi, bus.Flags[4:3]} !== {1'b1, 8'h00, 8'h00, 2'b10}) begin
         n_fail++;
         $display("FAIL add_ff_01: got v=%b r=%h hi=%h cy/ov=%b, required 1 00 00 10", got, bus.Rslt, bus.Rslt_hi, bus.Flags[4:3]);
      end
      run_op(4'd1, 8'h80, 8'h01, 1'b0, got, lat);
      model(1, 8'h80, 8'h01, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt, bus.Flags[4:3]} !== {1'b1, 8'h7F, 2'b01}) begin
         n_fail++;
         $display("FAIL sub_80_01: got v=%b r=%h cy/ov=%b, required 1 7f 01", got, bus.Rslt, bus.Flags[4:3]);
      end
   endtask

   task automatic test_cmp;
      bit got; int lat; longint r, hi;
      run_op(4'd6, 8'hFE, 8'h02, 1'b0, got, lat);
      model(6, 8'hFE, 8'h02, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt, bus.Flags[2:0]} !== {1'b1, 8'h00, 3'b100}) begin
         n_fail++;
         $display("FAIL cmp_unsigned: got v=%b r=%h gel=%b, required 1 00 100", got, bus.Rslt, bus.Flags[2:0]);
      end
      bus.Br_en = 1'b1; bus.Br_cond = 3'd6; #1;
      n_checks++;
      if (bus.Branch !== 1'b1) begin
         n_fail++;
         $display("FAIL cmp_unsigned_bgt: got %b, required 1", bus.Branch);
      end
      bus.Br_en = 1'b0;
      run_op(4'd6, 8'hFE, 8'h02, 1'b1, got, lat);
      model(6, 8'hFE, 8'h02, 1'b1, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Flags[2:0]} !== {1'b1, 3'b001}) begin
         n_fail++;
         $display("FAIL cmp_signed: got v=%b gel=%b, required 1 001", got, bus.Flags[2:0]);
      end
      bus.Br_en = 1'b1;
      bus.Br_cond = 3'd2; #1;
      n_checks++;
      if (bus.Branch !== 1'b1) begin
         n_fail++;
         $display("FAIL cmp_signed_blt: got %b, required 1", bus.Branch);
      end
      bus.Br_cond = 3'd1; #1;
      n_checks++;
      if (bus.Branch !== 1'b1) begin
         n_fail++;
         $display("FAIL cmp_signed_ble: got %b, required 1", bus.Branch);
      end
      bus.Br_cond = 3'd5; #1;
      n_checks++;
      if (bus.Branch !== 1'b0) begin
         n_fail++;
         $display("FAIL cmp_signed_bge: got %b, required 0", bus.Branch);
      end
      bus.Br_en = 1'b0;
   endtask

   task automatic test_mul_back_to_back;
      longint r, hi;
      bus.In_valid = 1'b1; bus.Alu_op = 4'd7; bus.DatA = 8'hFF; bus.DatB = 8'hFF;
      bus.Signed_cmp = 1'b0;
      n_checks++;
      if (bus.In_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mul_ready_at_offer: got %b, required 1", bus.In_ready);
      end
      @(posedge clk); #1;
      bus.In_valid = 1'b0;
      model(7, 8'hFF, 8'hFF, 1'b0, m_flags, r, hi, m_flags);
      for (int k = 1; k <= W - 1; k++) begin
         n_checks++;
         if ({bus.In_ready, bus.Out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL mul_busy_cycle_%0d: got rdy=%b v=%b, required 0 0", k, bus.In_ready, bus.Out_valid);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if ({bus.Out_valid, bus.In_ready, bus.Rslt_hi, bus.Rslt, bus.Flags[4:3]} !== {1'b1, 1'b1, 8'hFE, 8'h01, 2'b01}) begin
         n_fail++;
         $display("FAIL mul_ff_ff: got v=%b rdy=%b hi=%h r=%h cy/ov=%b, required 1 1 fe 01 01",
                  bus.Out_valid, bus.In_ready, bus.Rslt_hi, bus.Rslt, bus.Flags[4:3]);
      end
      bus.Br_en = 1'b1; bus.Br_cond = 3'd7; #1;
      n_checks++;
      if (bus.Branch !== 1'b1) begin
         n_fail++;
         $display("FAIL mul_bof: got %b, required 1", bus.Branch);
      end
      bus.Br_en = 1'b0;
      // ADD offered in the completion cycle is accepted at once.
      bus.In_valid = 1'b1; bus.Alu_op = 4'd0; bus.DatA = 8'h10; bus.DatB = 8'h20;
      @(posedge clk); #1;
      bus.In_valid = 1'b0;
      model(0, 8'h10, 8'h20, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({bus.Out_valid, bus.Rslt, bus.Rslt_hi} !== {1'b1, 8'h30, 8'h00}) begin
         n_fail++;
         $display("FAIL add_after_mul: got v=%b r=%h hi=%h, required 1 30 00", bus.Out_valid, bus.Rslt, bus.Rslt_hi);
      end
   endtask

   task automatic test_boundaries;
      bit got; int lat; longint r, hi;
      run_op(4'd8, 8'h80, 8'h00, 1'b0, got, lat);
      model(8, 8'h80, 8'h00, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt, bus.Flags[3]} !== {1'b1, 8'h80, 1'b1}) begin
         n_fail++;
         $display("FAIL abs_80: got v=%b r=%h ov=%b, required 1 80 1", got, bus.Rslt, bus.Flags[3]);
      end
      run_op(4'd8, 8'hF6, 8'h00, 1'b0, got, lat);
      model(8, 8'hF6, 8'h00, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt, bus.Flags[3]} !== {1'b1, 8'h0A, 1'b0}) begin
         n_fail++;
         $display("FAIL abs_f6: got v=%b r=%h ov=%b, required 1 0a 0", got, bus.Rslt, bus.Flags[3]);
      end
      run_op(4'd4, 8'h01, 8'h08, 1'b0, got, lat);
      model(4, 8'h01, 8'h08, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt} !== {1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL shl_by_8: got v=%b r=%h, required 1 00", got, bus.Rslt);
      end
      run_op(4'd5, 8'h80, 8'h07, 1'b0, got, lat);
      model(5, 8'h80, 8'h07, 1'b0, m_flags, r, hi, m_flags);
      n_checks++;
      if ({got, bus.Rslt} !== {1'b1, 8'h01}) begin
         n_fail++;
         $display("FAIL shr_by_7: got v=%b r=%h, required 1 01", got, bus.Rslt);
      end
   endtask

   task automatic test_random;
      bit got; int lat; longint r, hi;
      logic [3:0] op; logic [W-1:0] a, b; bit sc, en; int cond; bit exp_br;
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = W'($urandom);
         b  = (op == 4'd4 || op == 4'd5) ? W'($urandom_range(0, 15)) : W'($urandom);
         sc = 1'($urandom);
         model(int'(op), a, b, sc, m_flags, r, hi, m_flags);
         run_op(op, a, b, sc, got, lat);
         n_checks++;
         if ({got, lat} !== {1'b1, ((op == 4'd7) ? W : 1)}) begin
            n_fail++;
            $display("FAIL rand_%0d_latency op=%0d: got v=%b lat=%0d", i, op, got, lat);
         end
         n_checks++;
         if ({bus.Rslt, bus.Rslt_hi, bus.Flags} !== {W'(r), W'(hi), m_flags}) begin
            n_fail++;
            $display("FAIL rand_%0d op=%0d a=%h b=%h sc=%b: got r=%h hi=%h f=%b, required r=%h hi=%h f=%b",
                     i, op, a, b, sc, bus.Rslt, bus.Rslt_hi, bus.Flags, W'(r), W'(hi), m_flags);
         end
         en = 1'($urandom); cond = $urandom_range(0, 7);
         bus.Br_en = en; bus.Br_cond = 3'(cond); #1;
         exp_br = br_model(en, cond, m_flags);
         n_checks++;
         if (bus.Branch !== exp_br) begin
            n_fail++;
            $display("FAIL rand_%0d_branch en=%b cond=%0d: got %b, required %b", i, en, cond, bus.Branch, exp_br);
         end
         bus.Br_en = 1'b0;
      end
   endtask

   task automatic test_reset_mid_mul;
      bit got; int lat; bit seen;
      bus.In_valid = 1'b1; bus.Alu_op = 4'd7; bus.DatA = 8'h37; bus.DatB = 8'h5A;
      @(posedge clk); #1;
      bus.In_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_flags = 5'b0;
      n_checks++;
      if ({bus.In_ready, bus.Flags, bus.Out_valid} !== {1'b1, 5'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midmul_reset_state: got rdy=%b f=%b v=%b, required 1 00000 0", bus.In_ready, bus.Flags, bus.Out_valid);
      end
      seen = 1'b0;
      for (int k = 0; k < W + 2; k++) begin
         @(posedge clk); #1;
         if (bus.Out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midmul_aborted: got Out_valid seen=%b, required 0", seen);
      end
      run_op(4'd0, 8'h02, 8'h03, 1'b0, got, lat);
      n_checks++;
      if ({got, lat, bus.Rslt, bus.Flags} !== {1'b1, 32'd1, 8'h05, 5'b0}) begin
         n_fail++;
         $display("FAIL midmul_add_2_3: got v=%b lat=%0d r=%h f=%b, required 1 1 05 00000", got, lat, bus.Rslt, bus.Flags);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_flags  = 5'b0;
      rst_n    = 1'b0;
      bus.In_valid = 1'b0; bus.Alu_op = 4'd0; bus.Signed_cmp = 1'b0;
      bus.DatA = '0; bus.DatB = '0; bus.Br_en = 1'b0; bus.Br_cond = 3'd0;
      test_reset();
      test_add_sub();
      test_cmp();
      test_mul_back_to_back();
      test_boundaries();
      test_random();
      test_reset_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes WIDTH-bit arithmetic, logic and shift ops with a registered result, and an iterative shift-add multiplier taking WIDTH cycles.
- Keeps registered condition flags (lt/eq/gt/overflow/carry) with selectable signed/unsigned compare.
- Drives the core's branch decision combinationally from those flags. Sits between the register file read stage and writeback/PC logic.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
SHW, $clog2(WIDTH)+1, width of shift-amount field taken from DatB LSBs

Ports:
Clk  in  1  clock, all state on rising edge
Reset_n  in  1  synchronous active-low reset
In_valid  in  1  operation request
In_ready  out  1  block can accept; In_valid&In_ready = accept
Alu_op  in  4  0 ADD,1 SUB,2 AND,3 XOR,4 SHL,5 SHR,6 CMP,7 MUL,8 ABS,9 MOV; 10-15 reserved
Signed_cmp  in  1  CMP treats operands as two's complement when 1
DatA  in  WIDTH  operand A
DatB  in  WIDTH  operand B
Out_valid  out  1  one-cycle pulse, Rslt/Rslt_hi valid
Rslt  out  WIDTH  result (MUL low half)
Rslt_hi  out  WIDTH  MUL high half; 0 for other ops
Br_en  in  1  branch instruction in decode
Br_cond  in  3  0 always,1 BLE,2 BLT,3 BEQ,4 BNE,5 BGE,6 BGT,7 BOF
Branch  out  1  branch taken
Flags  out  5  {carry,overflow,gt,eq,lt} registered

Behaviour:
- Clock Clk, reset Reset_n: synchronous, active-low, one clock domain. Reset_n low at an edge: Out_valid=0, Rslt=0, Rslt_hi=0, Flags=0, busy=0, counter=0. An in-flight MUL is aborted with no Out_valid. Inputs are ignored while Reset_n is low.
- In_ready = !busy (combinational).
- Single-cycle ops (all except MUL), accepted at edge t: Rslt, Out_valid=1 and flags are visible after edge t+1. Out_valid returns to 0 the next cycle unless a new op is accepted. Rslt/Rslt_hi hold until the next Out_valid.
- ADD: R=A+B mod 2^W; carry=carry-out; overflow=(A[msb]==B[msb])&&(R[msb]!=A[msb]).
- SUB: R=A-B; carry=borrow (A<B unsigned); overflow=(A[msb]!=B[msb])&&(R[msb]!=A[msb]).
- AND, XOR, MOV(R=B): flags unchanged.
- SHL/SHR: logical shift; amount = DatB[SHW-1:0]; amount>=WIDTH gives R=0; flags unchanged.
- ABS: R=|A| two's complement. A=100..0 gives R=A and overflow=1, else overflow=0; carry unchanged.
- CMP: R=0, Out_valid pulses. lt/eq/gt set exactly one-hot per Signed_cmp; carry/overflow unchanged.
- Reserved op: R=0, Out_valid pulses, flags unchanged.
- MUL (unsigned):
  - Accept at t sets busy; WIDTH add-shift iterations follow.
  - Out_valid=1 with {Rslt_hi,Rslt}=A*B after edge t+WIDTH. busy clears on the same edge, so In_ready is high in that cycle and back-to-back accepts are legal.
  - Flags at completion: overflow=(Rslt_hi!=0); carry=0; lt/eq/gt unchanged.
- Branch = Br_en && cond(Flags), combinational from registered flags:
  - BLE=lt|eq, BLT=lt, BEQ=eq, BNE=!eq, BGE=gt|eq, BGT=gt, BOF=overflow.
  - cond 0 (always) is taken whenever Br_en is high.
  - Flag-writing ops accepted in cycle t affect Branch from cycle t+1. No forwarding; while busy, Branch uses pre-MUL flags.
- In_valid while busy: not accepted, no side effects; the requester holds the op.

Test Plan:
- WIDTH=8, reset: Reset_n=0 two edges -> Out_valid=0, Rslt=0, Flags=0, In_ready=1; Br_en=1, Br_cond=0 -> Branch=1; Br_cond=3 -> Branch=0.
- ADD overflow/carry: 0x7F+0x01 -> Rslt=0x80, overflow=1, carry=0. 0xFF+0x01 -> Rslt=0x00, carry=1, overflow=0. SUB 0x80-0x01 -> 0x7F, overflow=1.
- Signed vs unsigned CMP: A=0xFE, B=0x02. Signed_cmp=0 -> gt=1 and BGT taken next cycle. Signed_cmp=1 -> lt=1, BLT and BLE taken, BGE not taken.
- MUL latency/back-to-back: MUL 0xFF*0xFF accepted at t -> In_ready=0 for cycles t+1..t+7; Out_valid at t+8 with Rslt_hi=0xFE, Rslt=0x01, overflow=1 (BOF taken). ADD offered at t+8 is accepted; its result is at t+9.
- Boundaries: ABS 0x80 -> 0x80, overflow=1; ABS 0xF6 -> 0x0A, overflow=0; SHL 0x01 by 8 -> 0x00; SHR 0x80 by 7 -> 0x01.
- Reset mid-MUL: Reset_n=0 at t+3 of a MUL -> no Out_valid thereafter, In_ready=1 after the release edge, Flags=0; a new ADD 2+3 -> Rslt=0x05.
